// File: rtl/riscv_mem_watch.sv
// riscv_mem_watch: multi-channel watchpoint unit that observes riscv_core fetch and data buses.
// Optional macro RISCV_WATCH_CHAIN_EN makes channel k>0 count only while channel k-1 is triggered.
module riscv_mem_watch #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_W-1:0]       mem_d_addr_i,
    input  logic [DATA_W-1:0]       mem_d_data_wr_i,
    input  logic                    mem_d_rd_i,
    input  logic [3:0]              mem_d_wr_i,
    input  logic                    mem_d_accept_i,
    input  logic                    mem_i_rd_i,
    input  logic [ADDR_W-1:0]       mem_i_pc_i,
    input  logic                    mem_i_accept_i,
    input  logic                    cfg_wr_i,
    input  logic [CH_W-1:0]         cfg_ch_i,
    input  logic [1:0]              cfg_mode_i,
    input  logic [ADDR_W-1:0]       cfg_addr_val_i,
    input  logic [ADDR_W-1:0]       cfg_addr_mask_i,
    input  logic [DATA_W-1:0]       cfg_data_val_i,
    input  logic [DATA_W-1:0]       cfg_data_mask_i,
    input  logic [CNT_W-1:0]        cfg_thresh_i,
    input  logic [NUM_CH-1:0]       clear_i,
    output logic [NUM_CH-1:0]       hit_o,
    output logic                    irq_o,
    output logic [NUM_CH*CNT_W-1:0] cnt_o,
    output logic                    cap_valid_o,
    input  logic                    cap_ack_i,
    output logic [CH_W-1:0]         cap_ch_o,
    output logic [ADDR_W-1:0]       cap_addr_o,
    output logic [DATA_W-1:0]       cap_data_o,
    output logic                    cap_ovf_o
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIG  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RD = 2'b01;
    localparam logic [1:0] MODE_WR = 2'b10;
    localparam logic [1:0] MODE_IF = 2'b11;

    state_t            r_state      [NUM_CH];
    state_t            w_state_nxt  [NUM_CH];
    logic [1:0]        r_mode       [NUM_CH];
    logic [ADDR_W-1:0] r_addr_val   [NUM_CH];
    logic [ADDR_W-1:0] r_addr_mask  [NUM_CH];
    logic [DATA_W-1:0] r_data_val   [NUM_CH];
    logic [DATA_W-1:0] r_data_mask  [NUM_CH];
    logic [CNT_W-1:0]  r_thresh     [NUM_CH];
    logic [CNT_W-1:0]  r_cnt        [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nxt    [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_inc    [NUM_CH];
    logic [CNT_W-1:0]  w_thresh_eff [NUM_CH];

    logic [NUM_CH-1:0] w_cfg_sel;
    logic [NUM_CH-1:0] w_event;
    logic [NUM_CH-1:0] w_chain_ok;
    logic [NUM_CH-1:0] w_trig;

    logic              w_any_trig;
    logic [CH_W-1:0]   w_low_ch;
    logic [ADDR_W-1:0] w_low_addr;
    logic [DATA_W-1:0] w_low_data;

    logic              r_cap_valid;
    logic [CH_W-1:0]   r_cap_ch;
    logic [ADDR_W-1:0] r_cap_addr;
    logic [DATA_W-1:0] r_cap_data;
    logic              r_cap_ovf;

    // Per-channel bus event: strobe and accept together, masked address (and data for writes) match.
    always_comb begin
        w_event = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (r_mode[c])
                MODE_RD: w_event[c] = mem_d_rd_i & mem_d_accept_i &
                                      (((mem_d_addr_i ^ r_addr_val[c]) & r_addr_mask[c]) == '0);
                MODE_WR: w_event[c] = (|mem_d_wr_i) & mem_d_accept_i &
                                      (((mem_d_addr_i ^ r_addr_val[c]) & r_addr_mask[c]) == '0) &
                                      (((mem_d_data_wr_i ^ r_data_val[c]) & r_data_mask[c]) == '0);
                MODE_IF: w_event[c] = mem_i_rd_i & mem_i_accept_i &
                                      (((mem_i_pc_i ^ r_addr_val[c]) & r_addr_mask[c]) == '0);
                default: w_event[c] = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_chain_ok = '1;
`ifdef RISCV_WATCH_CHAIN_EN
        for (int c = 1; c < NUM_CH; c++) begin
            w_chain_ok[c] = (r_state[c-1] == ST_TRIG);
        end
`endif
    end

    // Next-state: config beats clear, clear beats a same-cycle event.
    always_comb begin
        w_cfg_sel = '0;
        w_trig    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c]  = r_state[c];
            w_cnt_nxt[c]    = r_cnt[c];
            w_cnt_inc[c]    = (r_cnt[c] == '1) ? r_cnt[c] : r_cnt[c] + CNT_W'(1);
            w_thresh_eff[c] = (r_thresh[c] == '0) ? CNT_W'(1) : r_thresh[c];
            w_cfg_sel[c]    = cfg_wr_i && (cfg_ch_i == CH_W'(c));

            if (w_cfg_sel[c]) begin
                w_state_nxt[c] = (cfg_mode_i == 2'b00) ? ST_OFF : ST_ARMED;
                w_cnt_nxt[c]   = '0;
            end else if (clear_i[c] && (r_state[c] != ST_OFF)) begin
                w_state_nxt[c] = ST_ARMED;
                w_cnt_nxt[c]   = '0;
            end else if ((r_state[c] == ST_ARMED) && w_event[c] && w_chain_ok[c]) begin
                w_cnt_nxt[c] = w_cnt_inc[c];
                if (w_cnt_inc[c] == w_thresh_eff[c]) begin
                    w_state_nxt[c] = ST_TRIG;
                    w_trig[c]      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c]     <= ST_OFF;
                r_mode[c]      <= '0;
                r_addr_val[c]  <= '0;
                r_addr_mask[c] <= '0;
                r_data_val[c]  <= '0;
                r_data_mask[c] <= '0;
                r_thresh[c]    <= '0;
                r_cnt[c]       <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_cnt[c]   <= w_cnt_nxt[c];
                if (w_cfg_sel[c]) begin
                    r_mode[c]      <= cfg_mode_i;
                    r_addr_val[c]  <= cfg_addr_val_i;
                    r_addr_mask[c] <= cfg_addr_mask_i;
                    r_data_val[c]  <= cfg_data_val_i;
                    r_data_mask[c] <= cfg_data_mask_i;
                    r_thresh[c]    <= cfg_thresh_i;
                end
            end
        end
    end

    // Descending scan so the lowest triggering channel is the one left selected.
    always_comb begin
        w_any_trig = |w_trig;
        w_low_ch   = '0;
        w_low_addr = '0;
        w_low_data = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_trig[c]) begin
                w_low_ch   = CH_W'(c);
                w_low_addr = (r_mode[c] == MODE_IF) ? mem_i_pc_i : mem_d_addr_i;
                w_low_data = (r_mode[c] == MODE_WR) ? mem_d_data_wr_i : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cap_valid <= 1'b0;
            r_cap_ch    <= '0;
            r_cap_addr  <= '0;
            r_cap_data  <= '0;
            r_cap_ovf   <= 1'b0;
        end else if (w_any_trig && (!r_cap_valid || cap_ack_i)) begin
            r_cap_valid <= 1'b1;
            r_cap_ch    <= w_low_ch;
            r_cap_addr  <= w_low_addr;
            r_cap_data  <= w_low_data;
        end else if (w_any_trig) begin
            r_cap_ovf <= 1'b1;
        end else if (cap_ack_i) begin
            r_cap_valid <= 1'b0;
        end
    end

    always_comb begin
        hit_o = '0;
        cnt_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit_o[c]                 = (r_state[c] == ST_TRIG);
            cnt_o[c*CNT_W +: CNT_W]  = r_cnt[c];
        end
    end

    assign irq_o       = |hit_o;
    assign cap_valid_o = r_cap_valid;
    assign cap_ch_o    = r_cap_ch;
    assign cap_addr_o  = r_cap_addr;
    assign cap_data_o  = r_cap_data;
    assign cap_ovf_o   = r_cap_ovf;

endmodule

// File: doc/riscv_mem_watch.md
# riscv_mem_watch

Parametrised multi-channel memory-bus watchpoint unit that monitors the riscv_core instruction-fetch and data-memory request interfaces. Each channel matches masked address/data patterns, counts occurrences against a programmable threshold, and raises a sticky hit flag and interrupt when the threshold is reached. The first triggering transaction is captured for readout through a valid/ack handshake. The unit instantiates beside the core, in the SoC or in a bench, and is purely observational: it never drives the core's buses.

## Interface
- NUM_CH, 4, number of watch channels (1..16)
- ADDR_W, 32, address/PC width
- DATA_W, 32, write-data width
- CNT_W, 16, occurrence counter and threshold width
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-low
- mem_d_addr_i / mem_d_data_wr_i  in  ADDR_W / DATA_W  data request address / write data
- mem_d_rd_i / mem_d_wr_i / mem_d_accept_i  in  1 / 4 / 1  data read strobe, byte write enables, request accepted
- mem_i_rd_i / mem_i_pc_i / mem_i_accept_i  in  1 / ADDR_W / 1  fetch strobe, fetch PC, fetch accepted
- cfg_wr_i  in  1  load config into channel cfg_ch_i
- cfg_ch_i  in  clog2(NUM_CH) (min 1)  target channel
- cfg_mode_i  in  2  00 off, 01 data read, 10 data write, 11 instruction fetch
- cfg_addr_val_i / cfg_addr_mask_i  in  ADDR_W  compare value / care mask (1 = compare bit)
- cfg_data_val_i / cfg_data_mask_i  in  DATA_W  write-data compare value / mask
- cfg_thresh_i  in  CNT_W  occurrences to trigger (0 treated as 1)
- clear_i  in  NUM_CH  per-channel clear of hit/counter, re-arm
- hit_o  out  NUM_CH  sticky per-channel trigger flags
- irq_o  out  1  OR of hit_o
- cnt_o  out  NUM_CH*CNT_W  per-channel counters, channel 0 in LSBs
- cap_valid_o / cap_ack_i  out / in  1 / 1  capture handshake
- cap_ch_o / cap_addr_o / cap_data_o  out  clog2(NUM_CH) / ADDR_W / DATA_W  captured channel, address or PC, write data (0 for read/fetch)
- cap_ovf_o  out  1  sticky: a trigger was lost while a capture was pending

## Operation
- Per-channel FSM: OFF -> ARMED on cfg_wr_i with mode != 00; ARMED -> TRIG when count reaches threshold; TRIG holds until clear_i or cfg_wr_i; any state -> OFF on cfg_wr_i with mode 00.
- Event: channel's strobe AND matching accept in the same cycle. Data read: mem_d_rd_i & mem_d_accept_i. Data write: (|mem_d_wr_i) & mem_d_accept_i. Fetch: mem_i_rd_i & mem_i_accept_i.
- Address match: ((addr ^ addr_val) & addr_mask) == 0; fetch uses mem_i_pc_i. Write mode also requires ((data ^ data_val) & data_mask) == 0. Read/fetch modes ignore data.
- Counter increments per event in ARMED only, saturating at 2^CNT_W-1; frozen in TRIG/OFF.
- Trigger: the event that makes count == max(thresh,1) sets hit, moves to TRIG.
- cfg_wr_i or clear_i zero counter and hit; cfg_wr_i same cycle as an event on that channel: config wins, event dropped. clear_i on an OFF channel: no state change.
- Capture: if cap_valid_o low, or high with cap_ack_i this cycle, the lowest-index triggering channel is loaded and cap_valid_o is set. Otherwise any trigger sets cap_ovf_o. Simultaneous triggers on multiple channels: only the lowest is captured; no overflow for others.
- cap_ack_i with no new trigger clears cap_valid_o. cap_ovf_o clears only on reset.

## Timing
- Reset (rst_i low at a clock edge): all channels OFF, config registers zero, counters 0, hit_o 0, irq_o 0, cap_valid_o 0, cap_ch/addr/data 0, cap_ovf_o 0. Reset mid-trigger discards everything.
- Latency: event in cycle N -> cnt_o updated, hit_o/irq_o/cap_valid_o high in cycle N+1.
- Config takes effect on the cycle after cfg_wr_i. An event in that following cycle is counted.
- One event per channel per cycle maximum. Data and fetch events in the same cycle are evaluated independently per channel mode.

## Configuration
- RISCV_WATCH_CHAIN_EN: when defined, channel k>0 counts only while channel k-1 is in TRIG, giving sequence triggers. Clearing channel k-1 freezes channel k's counting but does not clear it. When undefined, channels are fully independent. Channel 0 is unaffected either way.

## Test plan
- Reset: drive arbitrary inputs with rst_i=0 for 3 cycles -> all outputs 0, cnt_o=0.
- Ch0 mode 10, addr 0x8000_1000/mask 0xFFFF_FFFF, data 0xDEAD_BEEF/mask 0xFFFF_FFFF, thresh 3. Three accepted matching writes plus one with data 0xDEAD_BEEE -> cnt 3, hit_o[0]=1 and cap_valid_o=1 one cycle after the third, cap_addr_o=0x8000_1000, cap_data_o=0xDEAD_BEEF.
- Ch1 mode 11, PC 0x8000_0000/mask 0xFFFF_FF00, thresh 0. Fetch of 0x8000_0044 with accept=0, then accept=1 -> trigger only after the accepted fetch, cap_ch_o=1.
- Pending capture not acked, ch2 triggers -> cap_ovf_o=1, capture unchanged. Ack plus ch3 trigger in the same cycle -> cap_valid_o stays 1, cap_ch_o=3.
- cfg_wr_i to ch0 in the same cycle as a matching event -> cnt 0. Then clear_i[0] in TRIG -> ARMED, hit_o[0]=0.
- With RISCV_WATCH_CHAIN_EN: ch1 events before ch0 triggers -> cnt1 stays 0. After ch0 triggers, 2 events with thresh 2 -> hit_o[1]=1.
